// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame constants.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CSUM   = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam int HDR_LEN = 2;

    function automatic logic accepts_bytes(input state_t s);
        logic r;
        case (s)
            ST_HDR_LO, ST_HDR_HI, ST_DATA, ST_CSUM: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_word_pack.sv
// Assembles little-endian bytes into 32-bit words; word_valid pulses combinationally
// with the fourth byte so the caller can register the write on the same edge.
module imem_word_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;

    // Next byte index and shift contents
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (clear) begin
            idx_d   = 2'd0;
            shift_d = 24'd0;
        end else if (byte_valid) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {byte_data, shift_q[23:8]};
        end else begin
            idx_d   = idx_q;
            shift_d = shift_q;
        end
    end

    // Byte index and partial-word registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid = byte_valid && !clear && (idx_q == 2'd3);
    assign word       = {byte_data, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Frame-parsing loader: writes instruction memory and holds the core in reset until
// a checksum-verified image has been received.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    imem_loader_if.master     bus,
    input  logic              reload,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        acc_q, acc_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              core_reset_q, core_reset_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;

    logic              fire_s;
    logic              pack_clr_s;
    logic              pack_valid_s;
    logic              word_valid_s;
    logic [31:0]       word_s;
    logic [15:0]       hdr_n_s;
    logic              last_word_s;

    assign fire_s       = bus.in_valid && in_ready_q;
    assign pack_valid_s = fire_s && (state_q == ST_DATA);
    assign hdr_n_s      = {bus.in_data, cnt_q[7:0]};
    assign last_word_s  = (32'(wl_q) + 32'd1) == {16'd0, cnt_q};

    imem_word_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clear      (pack_clr_s),
        .byte_valid (pack_valid_s),
        .byte_data  (bus.in_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // Next-state, accumulator, word counter and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        wl_d         = wl_q;
        done_d       = done_q;
        error_d      = error_q;
        core_reset_d = core_reset_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        pack_clr_s   = 1'b0;

        case (state_q)
            ST_HDR_LO: begin
                if (fire_s) begin
                    cnt_d[7:0] = bus.in_data;
                    acc_d      = acc_q ^ bus.in_data;
                    state_d    = ST_HDR_HI;
                end else begin
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_HI: begin
                if (fire_s) begin
                    cnt_d[15:8] = bus.in_data;
                    acc_d       = acc_q ^ bus.in_data;
                    if ({16'd0, hdr_n_s} > 32'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else if (hdr_n_s == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_HDR_HI;
                end
            end
            ST_DATA: begin
                if (fire_s) begin
                    acc_d = acc_q ^ bus.in_data;
                end else begin
                    acc_d = acc_q;
                end
                if (word_valid_s) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ADDR_W'(BASE_ADDR) + wl_q[ADDR_W-1:0];
                    imem_wdata_d = word_s;
                    wl_d         = wl_q + 1'b1;
                    state_d      = last_word_s ? ST_CSUM : ST_DATA;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (fire_s) begin
                    if (bus.in_data == acc_q) begin
                        state_d      = ST_RUN;
                        done_d       = 1'b1;
                        core_reset_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_RUN, ST_ERR: begin
                // A new load starts from a clean slate; memory contents are left as-is
                if (reload) begin
                    state_d      = ST_HDR_LO;
                    core_reset_d = 1'b0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    wl_d         = '0;
                    acc_d        = 8'd0;
                    cnt_d        = 16'd0;
                    pack_clr_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_HDR_LO;
            end
        endcase

        in_ready_d = accepts_bytes(state_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_HDR_LO;
            cnt_q        <= 16'd0;
            acc_q        <= 8'd0;
            wl_q         <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            wl_q         <= wl_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_reset_q <= core_reset_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_reset     = core_reset_q;
    assign done           = done_q;
    assign error          = error_q;
    assign words_loaded   = wl_q;

endmodule
